// File: rtl/i2s_tx.sv
// I2S transmitter: 64-bit-period frames, left slot then right slot, MSB one bclk after lrcl edge.
// Double-buffered samples: a handshake-written holding register feeds a shadow register at frame start.
module i2s_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int BCLK_DIV   = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  enable_in,
  input  logic [DATA_WIDTH-1:0] left_in,
  input  logic [DATA_WIDTH-1:0] right_in,
  input  logic                  sample_valid_in,
  output logic                  sample_ready_out,
  output logic                  bclk_out,
  output logic                  lrcl_out,
  output logic                  sd_out,
  output logic                  frame_start_out,
  output logic                  underrun_out
);

  localparam int CW = $clog2(BCLK_DIV);
  localparam logic [CW-1:0] CYC_LAST = CW'(BCLK_DIV - 1);
  localparam logic [CW-1:0] CYC_HALF = CW'(BCLK_DIV / 2);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_cyc_cnt;
  logic [5:0]            r_bit_cnt;
  logic                  r_full;
  logic [DATA_WIDTH-1:0] r_hold_l;
  logic [DATA_WIDTH-1:0] r_hold_r;
  logic [DATA_WIDTH-1:0] r_shadow_l;
  logic [DATA_WIDTH-1:0] r_shadow_r;

  logic                  w_frame_start;
  logic                  w_frame_end;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_word;
  logic [31:0]           w_slot;

  assign w_frame_start = (r_state == ST_RUN) && (r_cyc_cnt == '0) && (r_bit_cnt == 6'd0) && !rst_in;
  assign w_frame_end   = (r_state == ST_RUN) && (r_cyc_cnt == CYC_LAST) && (r_bit_cnt == 6'd63);
  assign w_accept      = sample_valid_in && !r_full && !rst_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // enable_in is only looked at between frames, so a running frame always completes
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (enable_in) w_state_next = ST_RUN;
      ST_RUN:  if (w_frame_end && !enable_in) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || r_state == ST_IDLE) begin
      r_cyc_cnt <= '0;
      r_bit_cnt <= 6'd0;
    end else if (r_cyc_cnt == CYC_LAST) begin
      r_cyc_cnt <= '0;
      r_bit_cnt <= r_bit_cnt + 6'd1;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + CW'(1);
    end
  end

  // Acceptance implies the holding register was empty, so a frame-start load
  // on the same edge sees the old (empty) state and the new pair stays held.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_full     <= 1'b0;
      r_hold_l   <= '0;
      r_hold_r   <= '0;
      r_shadow_l <= '0;
      r_shadow_r <= '0;
    end else begin
      if (w_accept) begin
        r_full   <= 1'b1;
        r_hold_l <= left_in;
        r_hold_r <= right_in;
      end else if (w_frame_start) begin
        r_full <= 1'b0;
      end
      if (w_frame_start) begin
        r_shadow_l <= r_full ? r_hold_l : '0;
        r_shadow_r <= r_full ? r_hold_r : '0;
      end
    end
  end

  // Slot image MSB-first: bit 31 is the lrcl-edge bit, word occupies bits 30 downward.
  assign w_word = r_bit_cnt[5] ? r_shadow_r : r_shadow_l;
  assign w_slot = {{(32 - DATA_WIDTH){1'b0}}, w_word} << (31 - DATA_WIDTH);

  assign sample_ready_out = ~r_full;
  assign bclk_out         = (r_state == ST_RUN) && (r_cyc_cnt >= CYC_HALF);
  assign lrcl_out         = r_bit_cnt[5];
  assign sd_out           = w_slot[~r_bit_cnt[4:0]];
  assign frame_start_out  = w_frame_start;
  assign underrun_out     = w_frame_start & ~r_full;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx (DATA_WIDTH=16, BCLK_DIV=4): a monitor checks every frame against a
// scoreboard of expected frames; driver sequences cover handshake and frame-boundary cases.
module tb_i2s_tx;

  localparam int DW  = 16;
  localparam int DIV = 4;
  localparam int FRAME_CYC = 64 * DIV;

  logic          clk = 1'b0;
  logic          rst_in;
  logic          enable_in;
  logic [DW-1:0] left_in;
  logic [DW-1:0] right_in;
  logic          sample_valid_in;
  logic          sample_ready_out;
  logic          bclk_out;
  logic          lrcl_out;
  logic          sd_out;
  logic          frame_start_out;
  logic          underrun_out;

  typedef struct {
    logic          ur;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } frame_t;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    int            gap;
  } vec_t;

  frame_t sb_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  bit     at_fs   = 1'b0;

  i2s_tx #(.DATA_WIDTH(DW), .BCLK_DIV(DIV)) dut (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .enable_in       (enable_in),
    .left_in         (left_in),
    .right_in        (right_in),
    .sample_valid_in (sample_valid_in),
    .sample_ready_out(sample_ready_out),
    .bclk_out        (bclk_out),
    .lrcl_out        (lrcl_out),
    .sd_out          (sd_out),
    .frame_start_out (frame_start_out),
    .underrun_out    (underrun_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("[TB] FAIL %s: timed out", name);
  endtask

  // Expected 32-bit slot: 0 at k=0, word MSB-first at k=1..16, then zeros.
  function automatic logic [31:0] slot(input logic [DW-1:0] w);
    return {1'b0, w, 15'b0};
  endfunction

  task automatic wait_fs();
    int n;
    if (at_fs) begin
      at_fs = 1'b0;
      return;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start_out !== 1'b1 && n < 1000);
    if (frame_start_out !== 1'b1) fail_now("wait_frame_start");
  endtask

  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit record);
    int n;
    frame_t f;
    left_in = l;
    right_in = r;
    sample_valid_in = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sample_ready_out !== 1'b1 && n < 600);
    if (sample_ready_out !== 1'b1) fail_now("push_wait_ready");
    @(posedge clk);
    #1;
    sample_valid_in = 1'b0;
    if (record) begin
      f.ur = 1'b0; f.l = l; f.r = r;
      sb_q.push_back(f);
    end
    $display("[TB] push L=%h R=%h", l, r);
    @(negedge clk);
    at_fs = (frame_start_out === 1'b1);
    check("ready_after_accept", 64'(sample_ready_out), 64'd0);
  endtask

  // Frame monitor: pops one expected frame per frame_start_out and checks the whole frame.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (frame_start_out === 1'b1 && rst_in === 1'b0) begin
        frame_t      rec;
        logic [63:0] exp_sd;
        logic [63:0] cap;
        int          err;
        int          p;
        bit          aborted;
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL unexpected_frame: got frame start, expected none");
          rec.ur = 1'b1; rec.l = '0; rec.r = '0;
        end else begin
          rec = sb_q.pop_front();
        end
        check("frame_underrun", 64'(underrun_out), 64'(rec.ur));
        exp_sd  = {slot(rec.l), slot(rec.r)};
        cap     = '0;
        err     = 0;
        aborted = 1'b0;
        for (int c = 0; c < FRAME_CYC; c++) begin
          if (c > 0) @(negedge clk);
          if (rst_in === 1'b1) begin
            aborted = 1'b1;
            break;
          end
          p = c / DIV;
          if (bclk_out !== ((c % DIV) >= DIV / 2)) err++;
          if (lrcl_out !== (p >= 32)) err++;
          if (sd_out !== exp_sd[63-p]) err++;
          if (c > 0 && (frame_start_out !== 1'b0 || underrun_out !== 1'b0)) err++;
          if ((c % DIV) == DIV / 2) cap[63-p] = sd_out;
        end
        if (!aborted) begin
          check("frame_sd", cap, exp_sd);
          check("frame_wave_errs", 64'(err), 64'd0);
          $display("[TB] frame L=%h R=%h underrun=%0d sd=%h", rec.l, rec.r, rec.ur, cap);
        end else begin
          $display("[TB] frame aborted by reset");
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    vec_t   vecs[4];
    frame_t f;
    int     early;
    int     n;
    bit     quiet;

    vecs[0] = '{l: 16'hFFFF, r: 16'h0000, gap: 5};
    vecs[1] = '{l: 16'h0001, r: 16'h8000, gap: 100};
    vecs[2] = '{l: 16'h1234, r: 16'h5678, gap: 200};
    vecs[3] = '{l: 16'h7FFF, r: 16'h8001, gap: 255};

    rst_in = 1'b1;
    enable_in = 1'b0;
    sample_valid_in = 1'b0;
    left_in = '0;
    right_in = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bclk", 64'(bclk_out), 64'd0);
    check("rst_lrcl", 64'(lrcl_out), 64'd0);
    check("rst_sd", 64'(sd_out), 64'd0);
    check("rst_frame_start", 64'(frame_start_out), 64'd0);
    check("rst_underrun", 64'(underrun_out), 64'd0);
    check("rst_ready", 64'(sample_ready_out), 64'd1);

    // Start with nothing held: frame 0 underruns and is silent
    @(posedge clk);
    #1;
    rst_in = 1'b0;
    enable_in = 1'b1;
    f.ur = 1'b1; f.l = '0; f.r = '0;
    sb_q.push_back(f);
    wait_fs();

    repeat (20) @(posedge clk);
    #1;
    push_pair(16'h8001, 16'hA5A5, 1'b1);

    // Table: one pair per frame at varying offsets, last one on the final cycle before a frame
    for (int i = 0; i < 4; i++) begin
      wait_fs();
      repeat (vecs[i].gap) @(posedge clk);
      #1;
      push_pair(vecs[i].l, vecs[i].r, 1'b1);
    end

    // Back-to-back pairs: second waits for the frame-start load to free the holding register
    wait_fs();
    repeat (30) @(posedge clk);
    #1;
    left_in = 16'hC3C3;
    right_in = 16'h3C3C;
    sample_valid_in = 1'b1;
    @(negedge clk);
    check("b2b_ready_first", 64'(sample_ready_out), 64'd1);
    @(posedge clk);
    #1;
    f.ur = 1'b0; f.l = 16'hC3C3; f.r = 16'h3C3C;
    sb_q.push_back(f);
    left_in = 16'h0F0F;
    right_in = 16'hF0F0;
    early = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (frame_start_out !== 1'b1 && sample_ready_out !== 1'b0) early++;
    end while (frame_start_out !== 1'b1 && n < 600);
    if (frame_start_out !== 1'b1) fail_now("b2b_wait_frame_start");
    check("b2b_ready_held", 64'(early), 64'd0);
    check("b2b_ready_at_fs", 64'(sample_ready_out), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("b2b_ready_after_fs", 64'(sample_ready_out), 64'd1);
    @(posedge clk);
    #1;
    sample_valid_in = 1'b0;
    f.ur = 1'b0; f.l = 16'h0F0F; f.r = 16'hF0F0;
    sb_q.push_back(f);
    $display("[TB] push L=%h R=%h (back to back)", 16'h0F0F, 16'hF0F0);
    @(negedge clk);
    check("b2b_second_accepted", 64'(sample_ready_out), 64'd0);

    // Valid arrives exactly in a frame-start cycle with the holding register empty
    wait_fs();
    repeat (FRAME_CYC) @(posedge clk);
    #1;
    f.ur = 1'b1; f.l = '0; f.r = '0;
    sb_q.push_back(f);
    left_in = 16'h2468;
    right_in = 16'h9BDF;
    sample_valid_in = 1'b1;
    @(negedge clk);
    check("fs_edge_frame_start", 64'(frame_start_out), 64'd1);
    check("fs_edge_underrun", 64'(underrun_out), 64'd1);
    check("fs_edge_ready", 64'(sample_ready_out), 64'd1);
    @(posedge clk);
    #1;
    sample_valid_in = 1'b0;
    f.ur = 1'b0; f.l = 16'h2468; f.r = 16'h9BDF;
    sb_q.push_back(f);
    $display("[TB] push L=%h R=%h (at frame start)", 16'h2468, 16'h9BDF);
    @(negedge clk);
    check("fs_edge_held", 64'(sample_ready_out), 64'd0);

    // Drop enable at bit period 10: frame finishes, then the block goes quiet
    wait_fs();
    repeat (40) @(posedge clk);
    #1;
    enable_in = 1'b0;
    repeat (FRAME_CYC - 40) @(posedge clk);
    quiet = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (frame_start_out !== 1'b0 || bclk_out !== 1'b0 || lrcl_out !== 1'b0 || sd_out !== 1'b0)
        quiet = 1'b0;
    end
    check("idle_quiet", 64'(quiet), 64'd1);

    // Handshake while idle, then reset at cycle 70 of the loaded frame with another pair held
    @(posedge clk);
    #1;
    push_pair(16'hDEAD, 16'hBEEF, 1'b1);
    @(posedge clk);
    #1;
    enable_in = 1'b1;
    wait_fs();
    repeat (10) @(posedge clk);
    #1;
    push_pair(16'h1111, 16'h2222, 1'b0);
    repeat (59) @(posedge clk);
    #1;
    rst_in = 1'b1;
    enable_in = 1'b0;
    @(negedge clk);
    check("pre_reset_bclk_high", 64'(bclk_out), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_bclk", 64'(bclk_out), 64'd0);
    check("abort_lrcl", 64'(lrcl_out), 64'd0);
    check("abort_sd", 64'(sd_out), 64'd0);
    check("abort_ready", 64'(sample_ready_out), 64'd1);
    check("abort_pulses", 64'({frame_start_out, underrun_out}), 64'd0);

    // Held pair was discarded: the next frame underruns
    @(posedge clk);
    #1;
    rst_in = 1'b0;
    enable_in = 1'b1;
    f.ur = 1'b1; f.l = '0; f.r = '0;
    sb_q.push_back(f);
    wait_fs();
    @(posedge clk);
    #1;
    enable_in = 1'b0;
    repeat (FRAME_CYC + 8) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 16, giving the sample width per channel; legal range 8..31.
REQ-002 The module SHALL have parameter BCLK_DIV, default 32, giving clk_in cycles per bclk_out period; even, at least 4.
REQ-003 clk_in  input  1  system audio clock; all logic on its rising edge.
REQ-004 rst_in  input  1  reset, synchronous and active-high.
REQ-005 enable_in  input  1  run request, sampled only at frame boundaries.
REQ-006 left_in  input  DATA_WIDTH  left sample, two's complement.
REQ-007 right_in  input  DATA_WIDTH  right sample, two's complement.
REQ-008 sample_valid_in  input  1  left_in/right_in pair valid.
REQ-009 sample_ready_out  output  1  holding register empty; a pair is accepted when valid and ready are both high on the same edge.
REQ-010 bclk_out  output  1  I2S bit clock.
REQ-011 lrcl_out  output  1  I2S word select: 0 = left, 1 = right.
REQ-012 sd_out  output  1  I2S serial data.
REQ-013 frame_start_out  output  1  one-cycle pulse in the first cycle of each active frame.
REQ-014 underrun_out  output  1  one-cycle pulse when a frame starts with no sample held.

Function
REQ-015 A frame SHALL be 64 bit periods of BCLK_DIV cycles: slot 0 (left) is bit periods 0..31, slot 1 (right) is bit periods 32..63.
REQ-016 Within each bit period, bclk_out SHALL be 0 for the first BCLK_DIV/2 cycles and 1 for the remaining cycles.
REQ-017 lrcl_out and sd_out SHALL change only in the first cycle of a bit period, which is the bclk_out falling edge, and SHALL hold for the whole bit period.
REQ-018 lrcl_out SHALL be 0 during bit periods 0..31 and 1 during bit periods 32..63.
REQ-019 For slot bit index k = (bit period mod 32), sd_out SHALL be 0 at k=0, equal to word[DATA_WIDTH-k] for k=1..DATA_WIDTH (MSB first, one bclk after the lrcl edge), and 0 for k>DATA_WIDTH.
REQ-020 The design SHALL use two levels of storage: a holding register written by the handshake, and a shadow register that is serialised.
REQ-021 sample_ready_out SHALL equal NOT holding_full.
REQ-022 On acceptance, holding_full SHALL be set and the pair captured.
REQ-023 In the first cycle of each active frame, if holding_full is set, the shadow register SHALL load the holding pair and holding_full SHALL clear.
REQ-024 In the first cycle of each active frame, if holding_full is clear, the shadow register SHALL load zeros and underrun_out SHALL pulse.
REQ-025 If an acceptance and a frame-start load fall on the same edge, the frame start SHALL use the pre-edge holding state (no bypass), and the new pair SHALL remain held for the next frame.
REQ-026 Latency: a pair accepted before frame N's first cycle SHALL appear starting at frame N, bit period 1.
REQ-027 State machine: IDLE (bclk_out, lrcl_out, sd_out at 0; counters at 0) and RUN.
REQ-028 IDLE->RUN SHALL occur when enable_in=1; the next cycle is frame cycle 0.
REQ-029 RUN->IDLE SHALL occur only at the end of bit period 63 when enable_in=0; a frame in progress always completes.
REQ-030 The handshake SHALL operate in both IDLE and RUN.
REQ-031 Counters SHALL wrap: the cycle counter at BCLK_DIV-1 and the bit counter at 63, with no dead cycles between frames.

Reset
REQ-032 While rst_in=1, the module SHALL be in IDLE, with bclk_out, lrcl_out, sd_out, frame_start_out, underrun_out at 0, holding and shadow registers cleared, and sample_ready_out at 1.
REQ-033 While rst_in=1, no acceptance SHALL occur.
REQ-034 Reset asserted mid-frame SHALL abort the frame within one cycle and discard any held sample.

Verification (DATA_WIDTH=16, BCLK_DIV=4, frame = 256 cycles)
REQ-035 Reset for 3 cycles, enable_in=0 -> all serial outputs 0, sample_ready_out=1, no pulses.
REQ-036 Release reset with enable_in=1 and no sample -> frame_start_out and underrun_out pulse at cycle 0, sd_out 0 for the whole frame, bclk_out period 4 cycles, lrcl_out rises at cycle 128.
REQ-037 During frame 0, push L=16'h8001, R=16'hA5A5 -> frame 1: sd_out=1 in left bit periods 1 and 16 only; right slot bit periods 33..48 carry 1010010110100101; no underrun.
REQ-038 Push two pairs back to back mid-frame -> ready drops after the first and stays 0 until the next frame_start_out cycle, where the second pair is accepted in the following cycle.
REQ-039 Assert valid exactly in a frame_start cycle with holding empty -> underrun_out pulses that frame; the pair transmits in the next frame.
REQ-040 Drop enable_in at bit period 10 -> the frame completes through bit period 63, then the block idles; assert rst_in at cycle 70 of a loaded frame -> outputs are 0 on the next cycle and ready=1.
